multicycle_main_control: RTL and testbench

- Main control FSM for the multicycle RV32I datapath; it drives the ALUOp code consumed by the ALU control decoder.
- Sequences FETCH/DECODE/EXECUTE/MEM/WB per instruction from the 7-bit opcode.
- Handshakes with unified instruction/data memory via mem_ready.
- Counts retired instructions.

---
 rtl/multicycle_main_control.sv | 183 ++++++++++++++++++
 tb/tb_multicycle_main_control.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/multicycle_main_control.sv
// Main control FSM for the multicycle RV32I datapath: sequences FETCH..WB, drives datapath strobes/selects, counts retired instructions.
// Optional feature macro: ILLEGAL_TRAP_EN (unsupported opcodes trap instead of acting as NOPs).
module multicycle_main_control #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       opcode,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic             PCSource,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             MemtoReg,
    output logic             RegWrite,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic [3:0]       state_out,
    output logic [CNT_W-1:0] instret,
    output logic             illegal
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        REXEC  = 4'd6,
        IEXEC  = 4'd7,
        ALUWB  = 4'd8,
`ifdef ILLEGAL_TRAP_EN
        BRANCH = 4'd9,
        TRAP   = 4'd10
`else
        BRANCH = 4'd9
`endif
    } state_e;

    typedef enum logic [2:0] {
        CLS_NONE   = 3'd0,
        CLS_LOAD   = 3'd1,
        CLS_STORE  = 3'd2,
        CLS_RTYPE  = 3'd3,
        CLS_ITYPE  = 3'd4,
        CLS_BRANCH = 3'd5
    } class_e;

    state_e           state_q, state_d;
    class_e           class_q, class_d;
    logic [CNT_W-1:0] instret_q, instret_d;
    logic             retire;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= FETCH;
            class_q   <= CLS_NONE;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            class_q   <= class_d;
            instret_q <= instret_d;
        end
    end

    // The opcode is only trusted in DECODE; the latched class steers MEMADR afterwards.
    always_comb begin
        state_d = state_q;
        class_d = class_q;
        retire  = 1'b0;
        case (state_q)
            FETCH:  if (mem_ready) state_d = DECODE;
            DECODE: begin
                case (opcode)
                    OP_LOAD:   begin state_d = MEMADR; class_d = CLS_LOAD;   end
                    OP_STORE:  begin state_d = MEMADR; class_d = CLS_STORE;  end
                    OP_RTYPE:  begin state_d = REXEC;  class_d = CLS_RTYPE;  end
                    OP_ITYPE:  begin state_d = IEXEC;  class_d = CLS_ITYPE;  end
                    OP_BRANCH: begin state_d = BRANCH; class_d = CLS_BRANCH; end
                    default: begin
                        class_d = CLS_NONE;
`ifdef ILLEGAL_TRAP_EN
                        state_d = TRAP;
`else
                        state_d = FETCH;
`endif
                    end
                endcase
            end
            MEMADR: state_d = (class_q == CLS_STORE) ? MEMWR : MEMRD;
            MEMRD:  if (mem_ready) state_d = MEMWB;
            MEMWB:  begin state_d = FETCH; retire = 1'b1; end
            MEMWR: begin
                if (mem_ready) begin
                    state_d = FETCH;
                    retire  = 1'b1;
                end
            end
            REXEC:  state_d = ALUWB;
            IEXEC:  state_d = ALUWB;
            ALUWB:  begin state_d = FETCH; retire = 1'b1; end
            BRANCH: begin state_d = FETCH; retire = 1'b1; end
`ifdef ILLEGAL_TRAP_EN
            TRAP:   state_d = TRAP;
`endif
            default: state_d = FETCH;
        endcase
        instret_d = instret_q + {{(CNT_W-1){1'b0}}, retire};
    end

    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        PCSource    = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        ALUOp       = 2'b00;
        case (state_q)
            FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                PCWrite = mem_ready;
                IRWrite = mem_ready;
            end
            DECODE: ALUSrcB = 2'b10;
            MEMADR: begin ALUSrcA = 1'b1; ALUSrcB = 2'b10; end
            MEMRD:  begin MemRead = 1'b1; IorD = 1'b1; end
            MEMWB:  begin RegWrite = 1'b1; MemtoReg = 1'b1; end
            MEMWR:  begin MemWrite = 1'b1; IorD = 1'b1; end
            REXEC:  begin ALUSrcA = 1'b1; ALUOp = 2'b10; end
            IEXEC:  begin ALUSrcA = 1'b1; ALUSrcB = 2'b10; end
            ALUWB:  RegWrite = 1'b1;
            BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = 2'b01;
                PCWriteCond = 1'b1;
                PCSource    = 1'b1;
            end
            default: ;
        endcase
        // Reset must win combinationally so an abandoned instruction never writes on the reset edge.
        if (!rst_n) begin
            PCWrite     = 1'b0;
            PCWriteCond = 1'b0;
            PCSource    = 1'b0;
            IorD        = 1'b0;
            MemRead     = 1'b0;
            MemWrite    = 1'b0;
            IRWrite     = 1'b0;
            MemtoReg    = 1'b0;
            RegWrite    = 1'b0;
            ALUSrcA     = 1'b0;
            ALUSrcB     = 2'b00;
            ALUOp       = 2'b00;
        end
    end

    assign state_out = state_q;
    assign instret   = instret_q;
`ifdef ILLEGAL_TRAP_EN
    assign illegal   = (state_q == TRAP);
`else
    assign illegal   = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_main_control.sv
// Table-driven bench for multicycle_main_control (CNT_W=4 so the retire counter wraps quickly).
module tb_multicycle_main_control;

    localparam int CNT_W = 4;

    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_ST  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_BAD = 7'b1111111;

    // Control word: {PCWrite,PCWriteCond,PCSource,IorD,MemRead,MemWrite,IRWrite,MemtoReg,RegWrite,ALUSrcA,ALUSrcB,ALUOp}
    localparam logic [13:0] C_ZERO   = 14'b00000000000000;
    localparam logic [13:0] C_FETCH1 = 14'b10001010000100;
    localparam logic [13:0] C_FETCH0 = 14'b00001000000100;
    localparam logic [13:0] C_DECODE = 14'b00000000001000;
    localparam logic [13:0] C_MEMADR = 14'b00000000011000;
    localparam logic [13:0] C_MEMRD  = 14'b00011000000000;
    localparam logic [13:0] C_MEMWB  = 14'b00000001100000;
    localparam logic [13:0] C_MEMWR  = 14'b00010100000000;
    localparam logic [13:0] C_REXEC  = 14'b00000000010010;
    localparam logic [13:0] C_IEXEC  = 14'b00000000011000;
    localparam logic [13:0] C_ALUWB  = 14'b00000000100000;
    localparam logic [13:0] C_BRANCH = 14'b01100000010001;

    logic clk = 1'b0;
    logic rst_n, mem_ready;
    logic [6:0] opcode;
    logic PCWrite, PCWriteCond, PCSource, IorD, MemRead, MemWrite, IRWrite;
    logic MemtoReg, RegWrite, ALUSrcA, illegal;
    logic [1:0] ALUSrcB, ALUOp;
    logic [3:0] state_out;
    logic [CNT_W-1:0] instret;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string      name;
        logic       rst;
        logic [6:0] op;
        logic       mr;
        int         st;
        logic [13:0] ctrl;
        int         inst;
    } vec_t;

    vec_t vecs[$];

    multicycle_main_control #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .PCSource(PCSource),
        .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .state_out(state_out),
        .instret(instret), .illegal(illegal)
    );

    always #5 clk = ~clk;

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic [6:0] op, input logic mr);
        rst_n     = r;
        opcode    = op;
        mem_ready = mr;
    endtask

    // Samples on the falling edge, then advances past the next rising edge.
    task automatic checkOutput(input string name, input int st, input logic [13:0] ctrl,
                               input int inst, input logic ill);
        logic [13:0] act;
        @(negedge clk);
        act = {PCWrite, PCWriteCond, PCSource, IorD, MemRead, MemWrite, IRWrite,
               MemtoReg, RegWrite, ALUSrcA, ALUSrcB, ALUOp};
        checkVal({name, " state"}, 32'(state_out), 32'(st));
        checkVal({name, " ctrl"}, 32'(act), 32'(ctrl));
        checkVal({name, " instret"}, 32'(instret), 32'(inst));
        checkVal({name, " illegal"}, 32'(illegal), 32'(ill));
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mkVec(input string n, input logic r, input logic [6:0] op, input logic mr,
                                   input int st, input logic [13:0] c, input int inst);
        vec_t v;
        v.name = n; v.rst = r; v.op = op; v.mr = mr; v.st = st; v.ctrl = c; v.inst = inst;
        return v;
    endfunction

    initial begin
        vecs.push_back(mkVec("rst0",     1'b0, 7'd0,  1'b0, 0, C_ZERO,   0));
        vecs.push_back(mkVec("rst1",     1'b0, 7'd0,  1'b1, 0, C_ZERO,   0));
        vecs.push_back(mkVec("r_fetch",  1'b1, OP_R,  1'b1, 0, C_FETCH1, 0));
        vecs.push_back(mkVec("r_decode", 1'b1, OP_R,  1'b1, 1, C_DECODE, 0));
        vecs.push_back(mkVec("r_exec",   1'b1, OP_R,  1'b1, 6, C_REXEC,  0));
        vecs.push_back(mkVec("r_wb",     1'b1, OP_R,  1'b1, 8, C_ALUWB,  0));
        vecs.push_back(mkVec("ld_fetch", 1'b1, OP_LD, 1'b1, 0, C_FETCH1, 1));
        vecs.push_back(mkVec("ld_dec",   1'b1, OP_LD, 1'b1, 1, C_DECODE, 1));
        vecs.push_back(mkVec("ld_adr",   1'b1, OP_LD, 1'b1, 2, C_MEMADR, 1));
        vecs.push_back(mkVec("ld_rd_w1", 1'b1, OP_LD, 1'b0, 3, C_MEMRD,  1));
        vecs.push_back(mkVec("ld_rd_w2", 1'b1, OP_LD, 1'b0, 3, C_MEMRD,  1));
        vecs.push_back(mkVec("ld_rd_w3", 1'b1, OP_LD, 1'b0, 3, C_MEMRD,  1));
        vecs.push_back(mkVec("ld_rd",    1'b1, OP_LD, 1'b1, 3, C_MEMRD,  1));
        vecs.push_back(mkVec("ld_wb",    1'b1, OP_LD, 1'b1, 4, C_MEMWB,  1));
        vecs.push_back(mkVec("br_stall", 1'b1, OP_BR, 1'b0, 0, C_FETCH0, 2));
        vecs.push_back(mkVec("br_fetch", 1'b1, OP_BR, 1'b1, 0, C_FETCH1, 2));
        vecs.push_back(mkVec("br_dec",   1'b1, OP_BR, 1'b1, 1, C_DECODE, 2));
        vecs.push_back(mkVec("br_exec",  1'b1, OP_BR, 1'b1, 9, C_BRANCH, 2));
        vecs.push_back(mkVec("st_fetch", 1'b1, OP_ST, 1'b1, 0, C_FETCH1, 3));
        vecs.push_back(mkVec("st_dec",   1'b1, OP_ST, 1'b1, 1, C_DECODE, 3));
        vecs.push_back(mkVec("st_adr",   1'b1, OP_ST, 1'b1, 2, C_MEMADR, 3));
        vecs.push_back(mkVec("st_wr_w",  1'b1, OP_ST, 1'b0, 5, C_MEMWR,  3));
        vecs.push_back(mkVec("st_wr",    1'b1, OP_ST, 1'b1, 5, C_MEMWR,  3));

        // One unchecked reset edge so state_out is defined before the table starts.
        applyStimulus(1'b0, 7'd0, 1'b0);
        @(posedge clk);
        #1;

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].rst, vecs[i].op, vecs[i].mr);
            checkOutput(vecs[i].name, vecs[i].st, vecs[i].ctrl, vecs[i].inst, 1'b0);
        end

        // Store abandoned by reset while in MEMWR: no MemWrite on that edge, counter cleared.
        applyStimulus(1'b1, OP_ST, 1'b1);
        checkOutput("st2_fetch", 0, C_FETCH1, 4, 1'b0);
        checkOutput("st2_dec",   1, C_DECODE, 4, 1'b0);
        checkOutput("st2_adr",   2, C_MEMADR, 4, 1'b0);
        applyStimulus(1'b0, OP_ST, 1'b1);
        checkOutput("st2_wr_rst", 5, C_ZERO, 4, 1'b0);
        checkOutput("st2_after",  0, C_ZERO, 0, 1'b0);

        // Seventeen I-type instructions wrap the 4-bit counter 15 -> 0 -> 1.
        applyStimulus(1'b1, OP_I, 1'b1);
        for (int k = 0; k < 17; k++) begin
            checkOutput($sformatf("i%0d_fetch", k), 0, C_FETCH1, k % 16, 1'b0);
            checkOutput($sformatf("i%0d_dec", k),   1, C_DECODE, k % 16, 1'b0);
            checkOutput($sformatf("i%0d_exec", k),  7, C_IEXEC,  k % 16, 1'b0);
            checkOutput($sformatf("i%0d_wb", k),    8, C_ALUWB,  k % 16, 1'b0);
        end

        applyStimulus(1'b1, OP_BAD, 1'b1);
        checkOutput("bad_fetch", 0, C_FETCH1, 1, 1'b0);
        checkOutput("bad_dec",   1, C_DECODE, 1, 1'b0);
`ifdef ILLEGAL_TRAP_EN
        checkOutput("trap0", 10, C_ZERO, 1, 1'b1);
        checkOutput("trap1", 10, C_ZERO, 1, 1'b1);
        checkOutput("trap2", 10, C_ZERO, 1, 1'b1);
        applyStimulus(1'b0, OP_BAD, 1'b1);
        checkOutput("trap_rst", 10, C_ZERO, 1, 1'b1);
        checkOutput("trap_out", 0, C_ZERO, 0, 1'b0);
`else
        checkOutput("nop_fetch", 0, C_FETCH1, 1, 1'b0);
        checkOutput("nop_dec",   1, C_DECODE, 1, 1'b0);
        checkOutput("nop_again", 0, C_FETCH1, 1, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
